// File: rtl/decode_stage.sv
// RV32 decode stage: decodes fetch beats into a control bundle and
// buffers them in a small FIFO in front of execute.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_we,
  output logic             out_mem_we,
  output logic             out_writeback,
  output logic             out_is_jump,
  output logic             out_is_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLL  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_SLT  = 4'd8;
  localparam logic [3:0] A_SLTU = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            we;
    logic            mem_we;
    logic            writeback;
    logic            is_jump;
    logic            is_branch;
    logic            illegal;
  } ent_t;

  function automatic logic [XLEN-1:0] sext(
    input logic [31:0] v
  );
    return XLEN'(signed'(v));
  endfunction

  ent_t        w_dec;
  logic        w_ok;
  logic        w_f7z;
  logic        w_f7a;
  logic [2:0]  w_f3;
  logic [31:0] w_i;

  assign w_i   = in_inst;
  assign w_f3  = in_inst[14:12];
  assign w_f7z = (in_inst[31:25] == 7'h00);
  assign w_f7a = (in_inst[31:25] == 7'h20);

  always_comb begin
    w_dec        = '0;
    w_ok         = 1'b0;
    w_dec.pc     = in_pc;
    w_dec.opcode = w_i[6:0];
    w_dec.funct3 = w_f3;
    w_dec.funct7 = w_i[31:25];
    w_dec.rs1    = w_i[19:15];
    w_dec.rs2    = w_i[24:20];
    w_dec.rd     = w_i[11:7];
    unique case (w_i[6:0])
      7'b0110011: begin
        w_dec.we = 1'b1;
        unique case (w_f3)
          3'd0: begin
            w_ok         = w_f7z | w_f7a;
            w_dec.alu_op = w_f7a ? A_SUB : A_ADD;
          end
          3'd1: begin w_ok = w_f7z; w_dec.alu_op = A_SLL;  end
          3'd2: begin w_ok = w_f7z; w_dec.alu_op = A_SLT;  end
          3'd3: begin w_ok = w_f7z; w_dec.alu_op = A_SLTU; end
          3'd4: begin w_ok = w_f7z; w_dec.alu_op = A_XOR;  end
          3'd5: begin
            w_ok         = w_f7z | w_f7a;
            w_dec.alu_op = w_f7a ? A_SRA : A_SRL;
          end
          3'd6: begin w_ok = w_f7z; w_dec.alu_op = A_OR;   end
          default: begin
            w_ok         = w_f7z;
            w_dec.alu_op = A_AND;
          end
        endcase
      end
      7'b0010011: begin
        w_dec.we  = 1'b1;
        w_ok      = 1'b1;
        w_dec.imm = sext({{20{w_i[31]}}, w_i[31:20]});
        unique case (w_f3)
          3'd0: w_dec.alu_op = A_ADD;
          3'd2: w_dec.alu_op = A_SLT;
          3'd3: w_dec.alu_op = A_SLTU;
          3'd4: w_dec.alu_op = A_XOR;
          3'd6: w_dec.alu_op = A_OR;
          3'd7: w_dec.alu_op = A_AND;
          3'd1: begin
            w_ok         = w_f7z;
            w_dec.alu_op = A_SLL;
            w_dec.imm    = XLEN'(w_i[24:20]);
          end
          default: begin
            w_ok         = w_f7z | w_f7a;
            w_dec.alu_op = w_f7a ? A_SRA : A_SRL;
            w_dec.imm    = XLEN'(w_i[24:20]);
          end
        endcase
      end
      7'b0110111: begin
        w_ok            = 1'b1;
        w_dec.imm       = sext({w_i[31:12], 12'b0});
        w_dec.rs1       = 5'd0;
        w_dec.we        = 1'b1;
        w_dec.writeback = 1'b1;
      end
      7'b0010111: begin
        w_ok      = 1'b1;
        w_dec.imm = sext({w_i[31:12], 12'b0});
        w_dec.we  = 1'b1;
      end
      7'b1101111: begin
        w_ok            = 1'b1;
        w_dec.imm       = sext({{11{w_i[31]}}, w_i[31],
                                w_i[19:12], w_i[20],
                                w_i[30:21], 1'b0});
        w_dec.is_jump   = 1'b1;
        w_dec.we        = 1'b1;
        w_dec.writeback = 1'b1;
      end
      7'b1100111: begin
        w_ok            = (w_f3 == 3'd0);
        w_dec.imm       = sext({{20{w_i[31]}}, w_i[31:20]});
        w_dec.is_jump   = 1'b1;
        w_dec.we        = 1'b1;
        w_dec.writeback = 1'b1;
      end
      7'b1100011: begin
        w_ok            = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_dec.imm       = sext({{19{w_i[31]}}, w_i[31], w_i[7],
                                w_i[30:25], w_i[11:8], 1'b0});
        w_dec.is_branch = 1'b1;
        w_dec.alu_op    = A_SUB;
      end
      7'b0000011: begin
        w_ok            = (w_f3 == 3'd2);
        w_dec.imm       = sext({{20{w_i[31]}}, w_i[31:20]});
        w_dec.we        = 1'b1;
        w_dec.writeback = 1'b1;
      end
      7'b0100011: begin
        w_ok         = (w_f3 == 3'd2);
        w_dec.imm    = sext({{20{w_i[31]}}, w_i[31:25], w_i[11:7]});
        w_dec.mem_we = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
    // Illegal beats keep only the raw fields and pc.
    if (!w_ok) begin
      w_dec.imm       = '0;
      w_dec.alu_op    = A_ADD;
      w_dec.we        = 1'b0;
      w_dec.mem_we    = 1'b0;
      w_dec.writeback = 1'b0;
      w_dec.is_jump   = 1'b0;
      w_dec.is_branch = 1'b0;
      w_dec.illegal   = 1'b1;
    end
  end

  ent_t             r_mem [DEPTH];
  ent_t             r_hold;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_ill;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  ent_t             w_head;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;
  assign w_head    = w_empty ? r_hold : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_ill  <= '0;
      r_hold <= '0;
    end else begin
      if (!w_empty) r_hold <= r_mem[r_rd];
      if (flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop)  r_rd <= r_rd + 1'b1;
        if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
        else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        if (w_push && w_dec.illegal && (r_ill != '1))
          r_ill <= r_ill + 1'b1;
      end
    end
  end

  assign out_pc        = w_head.pc;
  assign out_opcode    = w_head.opcode;
  assign out_funct3    = w_head.funct3;
  assign out_funct7    = w_head.funct7;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_rd        = w_head.rd;
  assign out_imm       = w_head.imm;
  assign out_alu_op    = w_head.alu_op;
  assign out_we        = w_head.we;
  assign out_mem_we    = w_head.mem_we;
  assign out_writeback = w_head.writeback;
  assign out_is_jump   = w_head.is_jump;
  assign out_is_branch = w_head.is_branch;
  assign out_illegal   = w_head.illegal;
  assign illegal_count = r_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps then random traffic
// checked against a queue-based reference model of the stage.
module tb_decode_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic        out_we, out_mem_we, out_writeback;
  logic        out_is_jump, out_is_branch, out_illegal;
  logic [CNT_W-1:0] illegal_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_we(out_we), .out_mem_we(out_mem_we),
    .out_writeback(out_writeback),
    .out_is_jump(out_is_jump), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        we, mwe, wb, jmp, br, ill;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   ill_cnt;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 0;

  // Reference decode written from the ISA rules rather than the RTL.
  function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    int   rtab[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    int   f3, f7;
    bit   ok, shift, alt;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    e = '0;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    shift = (f3 == 1) || (f3 == 5);
    alt = (f7 == 32);
    e.pc = pc; e.op = i[6:0]; e.f3 = i[14:12]; e.f7 = i[31:25];
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    i12 = i[31:20];
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    ok = 0;
    case (i[6:0])
      7'h33: begin
        ok = (f7 == 0) || (alt && shift == (f3 == 5) && (f3 == 0 || f3 == 5));
        e.alu = 4'(rtab[f3]);
        if (alt) e.alu = (f3 == 0) ? 4'd1 : 4'd7;
        e.we = 1;
      end
      7'h13: begin
        ok = !shift || f7 == 0 || (f3 == 5 && alt);
        e.alu = 4'(rtab[f3]);
        if (f3 == 5 && alt) e.alu = 4'd7;
        e.imm = shift ? 32'(i[24:20]) : 32'($signed(i12));
        e.we = 1;
      end
      7'h37: begin
        ok = 1; e.imm = {i[31:12], 12'h000}; e.rs1 = 0;
        e.we = 1; e.wb = 1;
      end
      7'h17: begin ok = 1; e.imm = {i[31:12], 12'h000}; e.we = 1; end
      7'h6F: begin
        ok = 1; e.imm = 32'($signed(j21));
        e.jmp = 1; e.we = 1; e.wb = 1;
      end
      7'h67: begin
        ok = (f3 == 0); e.imm = 32'($signed(i12));
        e.jmp = 1; e.we = 1; e.wb = 1;
      end
      7'h63: begin
        ok = !(f3 == 2 || f3 == 3); e.imm = 32'($signed(b13));
        e.br = 1; e.alu = 1;
      end
      7'h03: begin
        ok = (f3 == 2); e.imm = 32'($signed(i12));
        e.we = 1; e.wb = 1;
      end
      7'h23: begin
        ok = (f3 == 2);
        e.imm = 32'($signed({i[31:25], i[11:7]}));
        e.mwe = 1;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.imm = 0; e.alu = 0; e.we = 0; e.mwe = 0;
      e.wb = 0; e.jmp = 0; e.br = 0; e.ill = 1;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = (q.size() > 0) ? q[0] : last;
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("count", 64'(illegal_count), 64'(ill_cnt));
    chk("pc", 64'(out_pc), 64'(e.pc));
    chk("fields", {out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd},
        {e.op, e.f3, e.f7, e.rs1, e.rs2, e.rd});
    chk("imm", 64'(out_imm), 64'(e.imm));
    chk("alu_op", 64'(out_alu_op), 64'(e.alu));
    chk("flags", 64'({out_we, out_mem_we, out_writeback,
                      out_is_jump, out_is_branch, out_illegal}),
        64'({e.we, e.mwe, e.wb, e.jmp, e.br, e.ill}));
  endtask

  task automatic cyc(input logic r, input logic v,
                     input logic [31:0] inst, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    bit push, pop;
    rst = r; in_valid = v; in_inst = inst; in_pc = pc;
    out_ready = rdy; flush = fl;
    if (armed) check_all();
    @(posedge clk);
    if (r) begin
      q.delete(); ill_cnt = 0; last = '0; armed = 1;
    end else begin
      if (q.size() > 0) last = q[0];
      if (fl) q.delete();
      else begin
        push = v && (q.size() < DEPTH);
        pop  = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(ref_dec(inst, pc));
          if (q[$].ill && ill_cnt < 3) ill_cnt++;
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                           7'h67, 7'h63, 7'h03, 7'h23};
    logic [31:0] i;
    int k;
    i = $urandom();
    k = $urandom_range(0, 10);
    if (k < 9) i[6:0] = ops[k];
    k = $urandom_range(0, 3);
    if (k < 2) i[31:25] = 7'h00;
    else if (k == 2) i[31:25] = 7'h20;
    if ($urandom_range(0, 2) == 0) i[14:12] = 3'd2;
    return i;
  endfunction

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_inst = 0; in_pc = 0;
    ill_cnt = 0; last = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);

    cyc(0, 1, 32'h00500093, 32'h100, 1, 0);
    chk("addi_imm", 64'(out_imm), 64'd5);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_wb", 64'({out_valid, out_we, out_writeback}), 64'b110);
    cyc(0, 1, 32'h402081B3, 32'h104, 1, 0);
    chk("sub_alu", 64'(out_alu_op), 64'd1);
    cyc(0, 1, 32'h0020A423, 32'h108, 1, 0);
    chk("sw_imm", 64'(out_imm), 64'd8);
    chk("sw_we", 64'({out_mem_we, out_we}), 64'b10);
    cyc(0, 1, 32'hFFDFF0EF, 32'h10C, 1, 0);
    chk("jal_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("jal_flags", 64'({out_is_jump, out_we, out_writeback}), 64'b111);
    cyc(0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'h00100113, 32'h200, 0, 0);
    cyc(0, 1, 32'h00200193, 32'h204, 0, 0);
    chk("full_ready", 64'(in_ready), 64'd0);
    cyc(0, 1, 32'h00300213, 32'h208, 0, 0);
    cyc(0, 1, 32'h00300213, 32'h208, 1, 0);
    cyc(0, 1, 32'h00300213, 32'h208, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'h00400293, 32'h300, 0, 0);
    cyc(0, 1, 32'h00500313, 32'h304, 0, 0);
    cyc(0, 1, 32'h00600393, 32'h308, 0, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);

    for (int n = 1; n <= 4; n++) begin
      cyc(0, 1, 32'hFFFFFFFF, 32'h400 + 32'(4 * n), 1, 0);
      chk("ill_flag", 64'({out_illegal, out_we, out_mem_we}), 64'b100);
      chk("ill_count", 64'(illegal_count), 64'((n > 3) ? 3 : n));
    end
    cyc(0, 1, 32'h00700413, 32'h500, 0, 0);
    cyc(1, 1, 32'h00800493, 32'h504, 0, 0);
    chk("mid_rst_cnt", 64'(illegal_count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);

    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          rnd_inst(), $urandom(), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 29) == 0));
    cyc(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, back-pressured instruction decode stage for the RV32 core. Sits between fetch and execute.
- Accepts {pc, instruction} beats over a valid/ready handshake, decodes them into a control bundle, and buffers results in a small FIFO.
- Supports pipeline flush, flags illegal encodings, and counts them.
- Adds a wider RV32I subset: shifts, compares, XOR, AUIPC and branches.

Parameters:
- XLEN, 32: width of pc and imm; must be ≥32; immediates are sign-extended to XLEN.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: discard all buffered and incoming beats this cycle.
- in_valid, in, 1: fetch beat valid.
- in_ready, out, 1: stage can accept a beat.
- in_inst, in, 32: instruction encoding.
- in_pc, in, XLEN: instruction address.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: execute consumes the head.
- out_pc, out, XLEN: pc of the head entry.
- out_opcode / out_funct3 / out_funct7, out, 7/3/7: raw instruction fields.
- out_rs1 / out_rs2 / out_rd, out, 5 each: register indices.
- out_imm, out, XLEN: decoded immediate.
- out_alu_op, out, 4: ALU control.
- out_we, out, 1: register-file write enable.
- out_mem_we, out, 1: data-memory write enable.
- out_writeback, out, 1: result comes from a non-ALU source (LUI, JAL, JALR, load).
- out_is_jump, out, 1: JAL or JALR.
- out_is_branch, out, 1: B-type.
- out_illegal, out, 1: unrecognised encoding.
- illegal_count, out, CNT_W: saturating count of accepted illegal beats.

Behaviour:
- Reset (sync): FIFO empty, out_valid=0, every out_* bundle field=0, illegal_count=0. in_ready=1 from the first cycle after reset.
- Handshakes:
  - Push occurs when in_valid&&in_ready. Pop occurs when out_valid&&out_ready.
  - in_ready = !full. This is registered-state only; there is no combinational path from out_ready.
- Latency: a beat accepted at edge N is at the head with out_valid=1 after edge N, if the FIFO was empty. Order is preserved.
- Simultaneous push and pop:
  - When full: push is refused (in_ready=0), pop proceeds.
  - When empty: push only, so the beat appears next cycle.
  - Otherwise: count is unchanged.
- Pointers wrap modulo DEPTH. The count range is 0..DEPTH.
- Flush has priority over push and pop. On the next edge count=0, out_valid=0, and any push in the flush cycle is dropped. illegal_count is not updated by a dropped beat.
- Out_* fields reflect the head entry while out_valid=1. They hold their last value while out_valid=0 and are zero after reset.
- Decode is combinational on in_inst and registered into the FIFO at push.
- Defaults for every decode: alu_op=ADD, all flags 0, imm=0.
- alu_op encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- R-type (0110011):
  - funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - Only funct7 0000000 is legal, plus 0100000 for SUB and SRA.
  - we=1.
- I-type ALU (0010011):
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI use imm=sext(inst[31:20]).
  - SLLI/SRLI/SRAI use a shamt in inst[24:20] and follow the same funct7 legality rule as R-type.
  - we=1.
- LUI (0110111): imm={inst[31:12],12'b0} sign-extended; rs1 forced to 0; alu ADD; we=1; writeback=1.
- AUIPC (0010111): same imm as LUI; alu ADD; we=1; execute uses pc as operand A.
- JAL (1101111): imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); is_jump=1; we=1; writeback=1.
- JALR (1100111): legal only with funct3=000; imm=sext(inst[31:20]); is_jump=1; we=1; writeback=1.
- Branch (1100011):
  - funct3 ∈ {000,001,100,101,110,111}.
  - imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - is_branch=1; alu SUB; we=0.
- Load (0000011): LW only (funct3=010); imm=sext(inst[31:20]); alu ADD; we=1; writeback=1.
- Store (0100011): SW only (funct3=010); imm=sext({inst[31:25],inst[11:7]}); alu ADD; mem_we=1; we=0.
- Illegal encodings (any other opcode or funct combination):
  - illegal=1 with we=mem_we=writeback=is_jump=is_branch=0 and alu_op=0.
  - The raw fields are still passed through.
- illegal_count increments on each accepted illegal push and saturates at 2^CNT_W−1.

Test Plan:
- Reset, then push 0x00500093 (ADDI x1,x0,5) with out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, we=1, writeback=0.
- Push 0x402081B3 (SUB x3,x1,x2) → alu_op=1, rd=3, rs1=1, rs2=2, we=1. Then push 0x0020A423 (SW x2,8(x1)) → imm=8, mem_we=1, we=0.
- Push 0xFFDFF0EF (JAL x1,−4) → imm=0xFFFFFFFC, is_jump=1, we=1, writeback=1, rd=1.
- Hold out_ready=0 and push 3 beats with DEPTH=2 → in_ready=0 after the 2nd; the 3rd is held by the source. Raise out_ready → the three beats emerge in order with pc intact and none lost or duplicated.
- Fill the FIFO, then assert flush for one cycle with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle beat never appears.
- Push 0xFFFFFFFF three times with CNT_W=2 → out_illegal=1, we=mem_we=0, and illegal_count steps 1,2,3 then stays 3 on a 4th push. Reset mid-stream → count=0 and FIFO empty on the next cycle.
